// File: rtl/fetch_aligner_if.sv
// Fetch-side bus bundle: instruction memory port, redirect port and
// the raw-instruction handshake towards the RVC expander.
`timescale 1ns/1ps
interface fetch_aligner_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr_data;
    logic [XLEN-1:0] instr_pc;

    // Aligner side.
    modport master (
        output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    // Environment side: memory, redirect source and instruction consumer.
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_aligner.sv
// Fetch aligner: fetches aligned 32-bit words, keeps them as a 4-deep
// halfword FIFO and presents one 16- or 32-bit raw instruction at a time.
// A 32-bit instruction may straddle two fetched words.
`timescale 1ns/1ps
module fetch_aligner #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              BUF_HW   = 4
) (
    input logic             clk,
    input logic             reset,
    fetch_aligner_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [15:0]     hw_buf   [BUF_HW];
    logic [15:0]     buf_next [BUF_HW];
    logic [2:0]      count;
    logic [2:0]      count_next;
    logic [2:0]      count_after_pop;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] cur_pc;
    logic            skip_low;

    logic            is_wide;
    logic            has_instr;
    logic            take;
    logic [1:0]      pop_n;
    logic            issue;
    logic            push;
    logic [1:0]      push_n;
    logic [1:0]      wr_idx;

    // The redirect target is halfword aligned, so its lowest bit is ignored.
    logic            unused_pc_bit;
    assign unused_pc_bit = bus.redirect_pc[0];

    // Decode buffer head, pop/push amounts and the fetch issue condition.
    always_comb begin
        is_wide         = (hw_buf[0][1:0] == 2'b11);
        has_instr       = ((count >= 3'd1) && !is_wide) || (count >= 3'd2);
        take            = has_instr && bus.instr_ready && !bus.redirect_valid;
        pop_n           = 2'd0;
        if (take) begin
            pop_n = is_wide ? 2'd2 : 2'd1;
        end
        count_after_pop = count - {1'b0, pop_n};
        issue           = (state == IDLE) && !reset && !bus.redirect_valid &&
                          (count_after_pop <= 3'd2);
        push            = (state == WAIT) && bus.imem_rvalid && !bus.redirect_valid;
        push_n          = skip_low ? 2'd1 : 2'd2;
        wr_idx          = count_after_pop[1:0];
        count_next      = count_after_pop + (push ? {1'b0, push_n} : 3'd0);
    end

    // Next buffer contents: drop popped entries, then append the new halfwords.
    always_comb begin
        for (int i = 0; i < BUF_HW; i++) begin
            buf_next[i] = hw_buf[i];
        end
        if (pop_n == 2'd1) begin
            for (int i = 0; i < BUF_HW - 1; i++) begin
                buf_next[i] = hw_buf[i + 1];
            end
        end else if (pop_n == 2'd2) begin
            for (int i = 0; i < BUF_HW - 2; i++) begin
                buf_next[i] = hw_buf[i + 2];
            end
        end
        if (push) begin
            if (skip_low) begin
                buf_next[wr_idx] = bus.imem_rdata[31:16];
            end else begin
                buf_next[wr_idx]        = bus.imem_rdata[15:0];
                buf_next[wr_idx + 2'd1] = bus.imem_rdata[31:16];
            end
        end
    end

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch FSM next state; a redirect turns an outstanding request into a drop.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    state_next = bus.imem_rvalid ? IDLE : DROP;
                end else if (bus.imem_rvalid) begin
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (bus.imem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: fetch request plus the instruction at the buffer head.
    always_comb begin
        bus.imem_req    = issue;
        bus.imem_addr   = fetch_pc;
        bus.instr_valid = has_instr;
        bus.instr_data  = 32'h0000_0000;
        if (has_instr) begin
            bus.instr_data = is_wide ? {hw_buf[1], hw_buf[0]} : {16'h0000, hw_buf[0]};
        end
        bus.instr_pc    = cur_pc;
    end

    // Control state: occupancy, fetch/instruction PCs and the skip flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 3'd0;
            fetch_pc <= RESET_PC;
            cur_pc   <= RESET_PC;
            skip_low <= 1'b0;
        end else if (bus.redirect_valid) begin
            count    <= 3'd0;
            cur_pc   <= {bus.redirect_pc[XLEN-1:1], 1'b0};
            fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            skip_low <= bus.redirect_pc[1];
        end else begin
            count <= count_next;
            if (take) begin
                cur_pc <= cur_pc + (is_wide ? XLEN'(4) : XLEN'(2));
            end
            if (push) begin
                fetch_pc <= fetch_pc + XLEN'(4);
                skip_low <= 1'b0;
            end
        end
    end

    // Halfword storage; entries beyond count are don't-care, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BUF_HW; i++) begin
            hw_buf[i] <= buf_next[i];
        end
    end
endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner with a small instruction memory model
// of configurable latency.
`timescale 1ns/1ps
module tb_fetch_aligner;
    logic clk;
    logic reset;

    fetch_aligner_if #(.XLEN(32)) bus ();

    fetch_aligner #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .BUF_HW   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem [0:127];
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    int          dly = 0;
    int          mem_lat = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The buffer must never hold more than four halfwords.
    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            assert (dut.count <= 3'd4) else begin
                fails++;
                $error("FAIL overflow: observed count %0d expected <= 4", dut.count);
            end
        end
    end

    // One clock: sample the request, clock the DUT, then drive the memory response.
    task automatic step();
        logic        req_seen;
        logic [31:0] addr_seen;
        logic        rst_seen;
        #1;
        req_seen  = bus.imem_req;
        addr_seen = bus.imem_addr;
        rst_seen  = reset;
        @(posedge clk);
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        if (rst_seen) begin
            pend = 1'b0;
        end else if (req_seen) begin
            check("one_outstanding", {63'd0, pend}, 64'd0);
            pend  = 1'b1;
            paddr = addr_seen;
            dly   = mem_lat;
        end
        if (pend) begin
            dly--;
            if (dly == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem[paddr[8:2]];
                pend = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        repeat (n) step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        reset = 1'b1;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;

        // Reset state, then a single 32-bit instruction.
        mem[0] = 32'h0051_0093;
        step();
        step();
        check("rst_req",   {63'd0, bus.imem_req}, 64'd0);
        check("rst_addr",  {32'd0, bus.imem_addr}, 64'h0);
        check("rst_valid", {63'd0, bus.instr_valid}, 64'd0);
        check("rst_data",  {32'd0, bus.instr_data}, 64'h0);
        check("rst_pc",    {32'd0, bus.instr_pc}, 64'h0);
        reset = 1'b0;
        mem_lat = 1;
        #1;
        check("t1_req",  {63'd0, bus.imem_req}, 64'd1);
        check("t1_addr", {32'd0, bus.imem_addr}, 64'h0);
        step();
        check("t1_wait_valid", {63'd0, bus.instr_valid}, 64'd0);
        step();
        check("t1_valid", {63'd0, bus.instr_valid}, 64'd1);
        check("t1_data",  {32'd0, bus.instr_data}, 64'h0051_0093);
        check("t1_pc",    {32'd0, bus.instr_pc}, 64'h0);
        check("t1_req2",  {63'd0, bus.imem_req}, 64'd1);
        check("t1_addr2", {32'd0, bus.imem_addr}, 64'h4);
        bus.instr_ready = 1'b1;
        step();
        check("t1_pc_next", {32'd0, bus.instr_pc}, 64'h4);

        // Two compressed instructions from one word.
        mem[0] = 32'h4501_0505;
        mem[1] = 32'h0000_0000;
        do_reset(1);
        bus.instr_ready = 1'b1;
        step();
        step();
        check("t2_valid0", {63'd0, bus.instr_valid}, 64'd1);
        check("t2_data0",  {32'd0, bus.instr_data}, 64'h0000_0505);
        check("t2_pc0",    {32'd0, bus.instr_pc}, 64'h0);
        step();
        check("t2_data1", {32'd0, bus.instr_data}, 64'h0000_4501);
        check("t2_pc1",   {32'd0, bus.instr_pc}, 64'h2);
        step();
        check("t2_pc2", {32'd0, bus.instr_pc}, 64'h4);

        // 32-bit instruction straddling two words, slow memory.
        mem[0] = 32'h0093_0505;
        mem[1] = 32'h0000_0051;
        do_reset(1);
        mem_lat = 3;
        bus.instr_ready = 1'b1;
        step();
        step();
        step();
        step();
        check("t3_c_valid", {63'd0, bus.instr_valid}, 64'd1);
        check("t3_c_data",  {32'd0, bus.instr_data}, 64'h0000_0505);
        check("t3_c_pc",    {32'd0, bus.instr_pc}, 64'h0);
        step();
        check("t3_hold_valid0", {63'd0, bus.instr_valid}, 64'd0);
        check("t3_hold_pc",     {32'd0, bus.instr_pc}, 64'h2);
        step();
        check("t3_hold_valid1", {63'd0, bus.instr_valid}, 64'd0);
        step();
        check("t3_hold_valid2", {63'd0, bus.instr_valid}, 64'd0);
        step();
        check("t3_w_valid", {63'd0, bus.instr_valid}, 64'd1);
        check("t3_w_data",  {32'd0, bus.instr_data}, 64'h0051_0093);
        check("t3_w_pc",    {32'd0, bus.instr_pc}, 64'h2);
        step();
        check("t3_next_pc", {32'd0, bus.instr_pc}, 64'h6);

        // Redirect to 0x102 while a request is outstanding.
        mem[0]  = 32'h2222_1111;
        mem[64] = 32'h0505_0093;
        do_reset(1);
        mem_lat = 3;
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0102;
        #1;
        check("t4_redir_req", {63'd0, bus.imem_req}, 64'd0);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check("t4_drop_req",   {63'd0, bus.imem_req}, 64'd0);
        check("t4_drop_pc",    {32'd0, bus.instr_pc}, 64'h102);
        check("t4_drop_valid", {63'd0, bus.instr_valid}, 64'd0);
        step();
        check("t4_stale_req", {63'd0, bus.imem_req}, 64'd0);
        step();
        check("t4_req",   {63'd0, bus.imem_req}, 64'd1);
        check("t4_addr",  {32'd0, bus.imem_addr}, 64'h100);
        check("t4_empty", {63'd0, bus.instr_valid}, 64'd0);
        step();
        step();
        step();
        step();
        check("t4_valid", {63'd0, bus.instr_valid}, 64'd1);
        check("t4_data",  {32'd0, bus.instr_data}, 64'h0000_0505);
        check("t4_pc",    {32'd0, bus.instr_pc}, 64'h102);
        check("t4_req2",  {63'd0, bus.imem_req}, 64'd1);
        check("t4_addr2", {32'd0, bus.imem_addr}, 64'h104);

        // Full buffer with the consumer stalled.
        mem[0] = 32'h0505_4501;
        mem[1] = 32'h0093_0505;
        do_reset(1);
        mem_lat = 1;
        step();
        step();
        check("t5_req1",  {63'd0, bus.imem_req}, 64'd1);
        check("t5_addr1", {32'd0, bus.imem_addr}, 64'h4);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            check("t5_stall_valid", {63'd0, bus.instr_valid}, 64'd1);
            check("t5_stall_data",  {32'd0, bus.instr_data}, 64'h0000_4501);
            check("t5_stall_pc",    {32'd0, bus.instr_pc}, 64'h0);
            check("t5_stall_req",   {63'd0, bus.imem_req}, 64'd0);
            step();
        end
        bus.instr_ready = 1'b1;
        #1;
        check("t5_pop_req",  {63'd0, bus.imem_req}, 64'd0);
        check("t5_pop_data", {32'd0, bus.instr_data}, 64'h0000_4501);
        step();
        check("t5_data2", {32'd0, bus.instr_data}, 64'h0000_0505);
        check("t5_pc2",   {32'd0, bus.instr_pc}, 64'h2);
        check("t5_req2",  {63'd0, bus.imem_req}, 64'd1);
        check("t5_addr2", {32'd0, bus.imem_addr}, 64'h8);

        // Redirect coinciding with a response, then reset during a wait.
        mem[0] = 32'h0000_4501;
        do_reset(1);
        mem_lat = 1;
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0040;
        #1;
        check("t6_redir_req", {63'd0, bus.imem_req}, 64'd0);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check("t6_req",   {63'd0, bus.imem_req}, 64'd1);
        check("t6_addr",  {32'd0, bus.imem_addr}, 64'h40);
        check("t6_valid", {63'd0, bus.instr_valid}, 64'd0);
        check("t6_pc",    {32'd0, bus.instr_pc}, 64'h40);
        mem_lat = 3;
        step();
        reset = 1'b1;
        #1;
        check("t6_rst_req0", {63'd0, bus.imem_req}, 64'd0);
        step();
        check("t6_rst_req",   {63'd0, bus.imem_req}, 64'd0);
        check("t6_rst_addr",  {32'd0, bus.imem_addr}, 64'h0);
        check("t6_rst_valid", {63'd0, bus.instr_valid}, 64'd0);
        check("t6_rst_data",  {32'd0, bus.instr_data}, 64'h0);
        check("t6_rst_pc",    {32'd0, bus.instr_pc}, 64'h0);
        reset = 1'b0;
        mem_lat = 1;
        #1;
        check("t6_restart_req",  {63'd0, bus.imem_req}, 64'd1);
        check("t6_restart_addr", {32'd0, bus.imem_addr}, 64'h0);
        step();
        step();
        check("t6_valid2", {63'd0, bus.instr_valid}, 64'd1);
        check("t6_data2",  {32'd0, bus.instr_data}, 64'h0000_4501);
        check("t6_pc2",    {32'd0, bus.instr_pc}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
